// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types and constants for the streaming binary-to-BCD
//                converter: FSM state encoding, BCD digit width and the
//                shift-add-3 adjust threshold.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of one BCD digit
    localparam int BCD_DIGIT_W = 4;

    // Digits strictly above this value get +3 before each shift
    localparam logic [3:0] ADD3_THRESHOLD = 4'd4;

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
//  Module      : bcd_digit_adjust
//  Description : Combinational double-dabble digit correction. A digit larger
//                than 4 gets +3 so that the following left shift carries
//                correctly into the next decimal digit. No carry leaves the
//                digit: inputs are always 0..9, so the result is 0..12.
//  Ports       : digit_i  in  4  BCD digit before adjust
//                digit_o  out 4  BCD digit after adjust
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i > ADD3_THRESHOLD) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule : bcd_digit_adjust

`default_nettype wire

// File: rtl/binary_to_bcd_stream.sv
// ============================================================================
//  Module      : binary_to_bcd_stream
//  Description : Streaming binary-to-BCD converter (shift-add-3, one input bit
//                per cycle, all digits adjusted in parallel). Valid/ready on
//                both sides, sticky overflow flag and leading-zero blank mask.
//                Feeds the seven-segment display drivers.
//  Config      : define BCD_SIGNED_EN to treat i_Binary as two's complement;
//                o_Negative then reports the sign and the magnitude is
//                converted. Undefined: unsigned input, o_Negative tied 0.
//  Ports       : i_Clock     in   1        clock, posedge
//                i_Rst_L     in   1        async reset, active-low
//                i_Binary    in   W        value to convert
//                i_Valid     in   1        i_Binary valid
//                o_Ready     out  1        input accepted this cycle
//                o_BCD       out  4*D      result, digit 0 in [3:0]
//                o_Valid     out  1        result valid, held until consumed
//                i_Ready     in   1        downstream takes result
//                o_Overflow  out  1        value >= 10^D (o_BCD is mod 10^D)
//                o_Blank     out  D        leading-zero mask, bit 0 always 0
//                o_Negative  out  1        input was negative (signed build)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module binary_to_bcd_stream
    import bcd_pkg::*;
#(
    parameter int INPUT_WIDTH    = 16,
    parameter int DECIMAL_DIGITS = 5
) (
    input  logic                                i_Clock,
    input  logic                                i_Rst_L,
    input  logic [INPUT_WIDTH-1:0]              i_Binary,
    input  logic                                i_Valid,
    output logic                                o_Ready,
    output logic [DECIMAL_DIGITS*BCD_DIGIT_W-1:0] o_BCD,
    output logic                                o_Valid,
    input  logic                                i_Ready,
    output logic                                o_Overflow,
    output logic [DECIMAL_DIGITS-1:0]           o_Blank,
    output logic                                o_Negative
);

    localparam int c_BCD_W = DECIMAL_DIGITS * BCD_DIGIT_W;
    localparam int c_CNT_W = $clog2(INPUT_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(INPUT_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t                   state_q, state_d;
    logic [INPUT_WIDTH-1:0]   bin_q,   bin_d;
    logic [c_BCD_W-1:0]       bcd_q,   bcd_d;
    logic [c_CNT_W-1:0]       cnt_q,   cnt_d;
    logic                     ovf_q,   ovf_d;
    logic                     neg_q,   neg_d;

    logic [c_BCD_W-1:0]       w_adj;
    logic [INPUT_WIDTH-1:0]   w_load_mag;
    logic                     w_load_neg;
    logic                     w_load;
    logic [DECIMAL_DIGITS-1:0] w_blank;
    logic                     w_above_zero;

    // ------------------------------------------------------------------
    // Load value: magnitude and sign of the incoming sample
    // ------------------------------------------------------------------
`ifdef BCD_SIGNED_EN
    // The most-negative value negates to itself, whose unsigned reading is
    // exactly its magnitude 2^(W-1), so no extra bit is needed.
    assign w_load_neg = i_Binary[INPUT_WIDTH-1];
    assign w_load_mag = i_Binary[INPUT_WIDTH-1] ? -i_Binary : i_Binary;
`else
    assign w_load_neg = 1'b0;
    assign w_load_mag = i_Binary;
`endif

    // ------------------------------------------------------------------
    // Per-digit add-3 correction, all digits in parallel
    // ------------------------------------------------------------------
    for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_digit
        bcd_digit_adjust u_adjust (
            .digit_i (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        w_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_Valid) begin
                    w_load  = 1'b1;
                    state_d = CONV;
                end
            end

            CONV: begin
                // Adjusted digits shift left, next binary bit enters at the
                // bottom; the bit leaving the top digit is a lost 10^D carry.
                bcd_d = {w_adj[c_BCD_W-2:0], bin_q[INPUT_WIDTH-1]};
                bin_d = {bin_q[INPUT_WIDTH-2:0], 1'b0};
                ovf_d = ovf_q | w_adj[c_BCD_W-1];
                cnt_d = cnt_q - c_CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (i_Ready) begin
                    if (i_Valid) begin
                        w_load  = 1'b1;
                        state_d = CONV;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_load) begin
            bin_d = w_load_mag;
            bcd_d = '0;
            cnt_d = c_CNT_LOAD;
            ovf_d = 1'b0;
            neg_d = w_load_neg;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask: digit k>0 blanks when it and every digit above it
    // is zero. Digit 0 always shows so that a value of 0 displays "0".
    // ------------------------------------------------------------------
    always_comb begin
        w_blank      = '0;
        w_above_zero = 1'b1;
        for (int k = DECIMAL_DIGITS - 1; k >= 1; k--) begin
            w_above_zero = w_above_zero & (bcd_q[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            w_blank[k]   = w_above_zero;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_Valid    = (state_q == DONE);
    // Gated by reset so the port reads 0 while reset is asserted
    assign o_Ready    = i_Rst_L & ((state_q == IDLE) | ((state_q == DONE) & i_Ready));
    assign o_BCD      = bcd_q;
    assign o_Overflow = ovf_q;
    assign o_Negative = neg_q;
    assign o_Blank    = o_Valid ? w_blank : '0;

endmodule : binary_to_bcd_stream

`default_nettype wire
